// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Sequencing controller for the multi-cycle lab processor datapath. It walks
// the shared ALU, register file and single-port memory through FETCH,
// DECODE, EXEC, MEM and WB, one instruction at a time. It also waits on a
// memory ready handshake, so memory latency may vary.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous, active-high reset
//   opcode[3:0] in   IR opcode, valid in DECODE
//   zero        in   ALU zero flag, sampled in EXEC (BEQ)
//   mem_ready   in   memory finishes the current access this cycle
//   mem_rd      out  memory read request (fetch or LW)
//   mem_wr      out  memory write request (SW)
//   ir_en       out  load IR from memory data
//   pc_inc      out  PC <= PC + 1
//   pc_load     out  PC <= target (J, taken BEQ)
//   alu_op[2:0] out  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
//   alu_src     out  0 = register B, 1 = immediate
//   write_en    out  register-file write
//   wb_sel      out  0 = ALU result, 1 = memory data
//   instr_done  out  pulse in the last cycle of each instruction
//   halted      out  controller is in HALT
//   err         out  memory timeout seen, sticky until reset
//
// Parameters:
//   TIMEOUT_CYC  maximum consecutive memory wait cycles (4-bit counter)
//
// Build option:
//   MCTRL_TIMEOUT_EN  when defined, a memory wait of TIMEOUT_CYC cycles in
//                     FETCH or MEM forces HALT and sets err. When undefined,
//                     waits are unbounded and err is tied low.
//
// State   | meaning
// --------+---------------------------------------------------------------
// INIT    | one idle cycle after reset, all outputs low
// FETCH   | read instruction; on mem_ready load IR and bump PC
// DECODE  | capture opcode; J, HLT and illegal opcodes finish here
// EXEC    | drive ALU; BEQ resolves here
// MEM     | data access for LW/SW, held until mem_ready
// WB      | register-file write (ALU result or load data)
// HALT    | absorbing, only rst leaves
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_en,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic       write_en,
  output logic       wb_sel,
  output logic       instr_done,
  output logic       halted,
  output logic       err
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_J    = 4'b1100;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op_q;
  logic       w_legal;
  logic       w_op_lw;
  logic       w_op_sw;

  function automatic logic f_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI,
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_HLT: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // DECODE must act on the live opcode: r_op_q only becomes valid after it.
  assign w_legal = f_legal(opcode);
  assign w_op_lw = (r_op_q == OP_LW);
  assign w_op_sw = (r_op_q == OP_SW);

`ifdef MCTRL_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYC - 1);

  logic [3:0] r_wait_cnt;
  logic       r_err;
  logic       w_waiting;
  logic       w_timeout;

  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  // This wait cycle is the TIMEOUT_CYC-th one in a row.
  assign w_timeout = w_waiting && (r_wait_cnt == TO_LAST);
  assign err       = r_err;
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign err                  = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_J)       w_next = S_FETCH;
        else if (opcode == OP_HLT) w_next = S_HALT;
        else if (!w_legal)         w_next = S_FETCH;
        else                       w_next = S_EXEC;
      end
      S_EXEC: begin
        case (r_op_q)
          OP_LW, OP_SW: w_next = S_MEM;
          OP_BEQ:       w_next = S_FETCH;
          default:      w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) w_next = w_op_lw ? S_WB : S_FETCH;
      end
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_INIT;
    endcase
`ifdef MCTRL_TIMEOUT_EN
    if (w_timeout) w_next = S_HALT;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_op_q  <= 4'b0000;
`ifdef MCTRL_TIMEOUT_EN
      r_wait_cnt <= 4'd0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= opcode;
`ifdef MCTRL_TIMEOUT_EN
      // Only consecutive waits within one state count toward the limit.
      if (w_next != r_state)  r_wait_cnt <= 4'd0;
      else if (w_waiting)     r_wait_cnt <= r_wait_cnt + 4'd1;
      if (w_timeout)          r_err <= 1'b1;
`endif
    end
  end

  // Moore outputs from state and r_op_q. The only input terms are the
  // handshake/flag qualifiers (mem_ready in FETCH/MEM, zero in EXEC) and the
  // live opcode in DECODE.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_en      = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    write_en   = 1'b0;
    wb_sel     = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_en  = mem_ready;
        pc_inc = mem_ready;
      end
      S_DECODE: begin
        if (opcode == OP_J) begin
          pc_load    = 1'b1;
          instr_done = 1'b1;
        end else if (!w_legal) begin
          instr_done = 1'b1;
        end
      end
      S_EXEC: begin
        case (r_op_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
            // Register-register opcodes carry the ALU encoding in their low bits.
            alu_op  = r_op_q[2:0];
            alu_src = 1'b0;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            alu_op  = ALU_ADD;
            alu_src = 1'b1;
          end
          OP_BEQ: begin
            alu_op     = ALU_SUB;
            alu_src    = 1'b0;
            pc_load    = zero;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_rd     = w_op_lw;
        mem_wr     = w_op_sw;
        instr_done = w_op_sw && mem_ready;
      end
      S_WB: begin
        write_en   = 1'b1;
        wb_sel     = w_op_lw;
        instr_done = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'b0000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_rd, mem_wr, ir_en, pc_inc, pc_load;
  logic [2:0] alu_op;
  logic       alu_src, write_en, wb_sel, instr_done, halted, err;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .ir_en      (ir_en),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .write_en   (write_en),
    .wb_sel     (wb_sel),
    .instr_done (instr_done),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef logic [13:0] ovec_t;
  ovec_t w_obs;
  assign w_obs = {mem_rd, mem_wr, ir_en, pc_inc, pc_load, alu_op,
                  alu_src, write_en, wb_sel, instr_done, halted, err};

  localparam ovec_t B_RD   = 14'h2000;
  localparam ovec_t B_WR   = 14'h1000;
  localparam ovec_t B_IR   = 14'h0800;
  localparam ovec_t B_INC  = 14'h0400;
  localparam ovec_t B_LD   = 14'h0200;
  localparam ovec_t B_SRC  = 14'h0020;
  localparam ovec_t B_WE   = 14'h0010;
  localparam ovec_t B_WBS  = 14'h0008;
  localparam ovec_t B_DONE = 14'h0004;
  localparam ovec_t B_HLT  = 14'h0002;
  localparam ovec_t B_ERR  = 14'h0001;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4,  OP_ADDI = 4'd5, OP_LW = 4'd8, OP_SW = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd10, OP_J = 4'd12,  OP_HLT = 4'd15;

  typedef struct {
    ovec_t      exp;
    logic       rdy;
    logic [3:0] opc;
    logic       z;
  } cyc_t;

  cyc_t trace[$];

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic ovec_t aop(input logic [2:0] a);
    return {5'b0, a, 6'b0};
  endfunction

  function automatic bit legal(input logic [3:0] op);
    return (op <= OP_ADDI) || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_J || op == OP_HLT;
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      OP_ADD:  return 3'b000;
      OP_SUB:  return 3'b001;
      OP_AND:  return 3'b010;
      OP_OR:   return 3'b011;
      OP_SLT:  return 3'b100;
      OP_BEQ:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Zero-wait latency, FETCH through the instr_done cycle.
  function automatic int lat_of(input logic [3:0] op);
    if (op == OP_J || !legal(op)) return 2;
    if (op == OP_BEQ)             return 3;
    if (op == OP_LW)              return 5;
    return 4;
  endfunction

  task automatic push(input ovec_t e, input logic r, input logic [3:0] o, input logic z);
    trace.push_back('{e, r, o, z});
  endtask

  // Expected per-cycle outputs and stimulus for one instruction. Cycles
  // where an input is ignored get random values on that input.
  task automatic build(input logic [3:0] op, input logic z, input int fw, input int mw);
    bit is_mem;
    bit is_lw;
    is_lw  = (op == OP_LW);
    is_mem = is_lw || (op == OP_SW);
    trace.delete();
    for (int i = 0; i < fw; i++) push(B_RD, 1'b0, rop(), rbit());
    push(B_RD | B_IR | B_INC, 1'b1, rop(), rbit());
    if (op == OP_J)  begin push(B_LD | B_DONE, rbit(), op, rbit()); return; end
    if (op == OP_HLT) begin push('0, rbit(), op, rbit()); return; end
    if (!legal(op))  begin push(B_DONE, rbit(), op, rbit()); return; end
    push('0, rbit(), op, rbit());
    if (op == OP_BEQ) begin
      push(aop(alu_of(op)) | (z ? B_LD : '0) | B_DONE, rbit(), rop(), z);
      return;
    end
    push(aop(alu_of(op)) | ((is_mem || op == OP_ADDI) ? B_SRC : '0), rbit(), rop(), rbit());
    if (is_mem) begin
      for (int i = 0; i < mw; i++) push(is_lw ? B_RD : B_WR, 1'b0, rop(), rbit());
      push(is_lw ? B_RD : (B_WR | B_DONE), 1'b1, rop(), rbit());
      if (!is_lw) return;
    end
    push(B_WE | (is_lw ? B_WBS : '0) | B_DONE, rbit(), rop(), rbit());
  endtask

  task automatic drive_cycle(input int idx);
    @(negedge clk);
    mem_ready = trace[idx].rdy;
    opcode    = trace[idx].opc;
    zero      = trace[idx].z;
    #1;
  endtask

  task automatic run_instr(input string name, input logic [3:0] op, input logic z,
                           input int fw, input int mw);
    int done_at;
    int exp_lat;
    done_at = -1;
    build(op, z, fw, mw);
    for (int i = 0; i < trace.size(); i++) begin
      drive_cycle(i);
      n_checks++;
      if (w_obs !== trace[i].exp) begin
        n_errors++;
        $display("FAIL %s op=%b cycle %0d: outputs got %b, expected %b",
                 name, op, i, w_obs, trace[i].exp);
      end
      if (instr_done === 1'b1 && done_at < 0) done_at = i + 1;
    end
    if (op != OP_HLT) begin
      exp_lat = lat_of(op) + fw + ((op == OP_LW || op == OP_SW) ? mw : 0);
      n_checks++;
      if (done_at !== exp_lat) begin
        n_errors++;
        $display("FAIL %s_latency op=%b: got %0d cycles, expected %0d", name, op, done_at, exp_lat);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = rbit(); opcode = rop(); zero = rbit();
    @(negedge clk);
    #1;
    n_checks++;
    if (w_obs !== '0) begin
      n_errors++;
      $display("FAIL reset_active: outputs got %b, expected 0", w_obs);
    end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== '0) begin
      n_errors++;
      $display("FAIL init_cycle: outputs got %b, expected 0", w_obs);
    end
  endtask

  task automatic test_sub();
    run_instr("sub", OP_SUB, 1'b0, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", OP_LW, 1'b0, 0, 3);
    run_instr("lw_fetch_wait", OP_LW, 1'b0, 2, 1);
    run_instr("sw", OP_SW, 1'b0, 0, 0);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", OP_BEQ, 1'b1, 0, 0);
    run_instr("beq_not_taken", OP_BEQ, 1'b0, 0, 0);
  endtask

  task automatic test_jump_illegal();
    run_instr("jump", OP_J, 1'b0, 0, 0);
    run_instr("illegal_0110", 4'b0110, 1'b0, 0, 0);
    run_instr("illegal_1110", 4'b1110, 1'b0, 1, 0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    for (int k = 0; k < 40; k++) begin
      op = rop();
      if (op == OP_HLT) op = OP_ADDI;
      run_instr("random", op, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_halt();
    run_instr("hlt", OP_HLT, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = rbit(); opcode = rop(); zero = rbit();
      #1;
      n_checks++;
      if (w_obs !== B_HLT) begin
        n_errors++;
        $display("FAIL halt_hold cycle %0d: outputs got %b, expected %b", i, w_obs, B_HLT);
      end
    end
    test_reset();
    run_instr("after_halt", OP_ADD, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_mem();
    // FETCH, DECODE, EXEC, then one MEM wait cycle of a store.
    build(OP_SW, 1'b0, 0, 5);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(i);
      n_checks++;
      if (w_obs !== trace[i].exp) begin
        n_errors++;
        $display("FAIL mid_mem_pre cycle %0d: outputs got %b, expected %b", i, w_obs, trace[i].exp);
      end
    end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (w_obs !== '0) begin
      n_errors++;
      $display("FAIL mid_mem_reset: outputs got %b, expected 0 (mem_wr=%b)", w_obs, mem_wr);
    end
    rst = 1'b0; mem_ready = 1'b1;
    run_instr("after_mid_reset", OP_OR, 1'b0, 0, 0);
  endtask

`ifdef MCTRL_TIMEOUT_EN
  task automatic test_timeout();
    int mem_cycles;
    bit seen_halt;
    mem_cycles = 0;
    seen_halt  = 0;
    build(OP_SW, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(i);
    for (int i = 0; i < 40 && !seen_halt; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (halted === 1'b1) seen_halt = 1;
      else if (mem_wr === 1'b1) mem_cycles++;
    end
    n_checks++;
    if (mem_cycles != 15 || !seen_halt) begin
      n_errors++;
      $display("FAIL timeout_mem_cycles: got %0d (halted=%0d), expected 15", mem_cycles, seen_halt);
    end
    n_checks++;
    if (w_obs !== (B_HLT | B_ERR)) begin
      n_errors++;
      $display("FAIL timeout_halt_err: outputs got %b, expected %b", w_obs, B_HLT | B_ERR);
    end
    test_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_sub();
    test_lw_wait();
    test_beq();
    test_jump_illegal();
    test_back_to_back();
    test_halt();
    test_reset_mid_mem();
`ifdef MCTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the lab processor datapath. It sequences the shared ALU, register file and single-port memory through fetch, decode, execute, memory and write-back phases, one instruction at a time. It decodes the 4-bit opcode into register write-enable, 3-bit ALU operation and memory/PC strobes. It waits on a memory ready handshake, so the datapath tolerates variable-latency memory.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 15: maximum memory wait cycles. Used only when `MCTRL_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  4  instruction opcode from the IR; valid in DECODE
- `zero`  in  1  ALU zero flag; sampled in EXEC
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_rd`  out  1  memory read request (fetch or load)
- `mem_wr`  out  1  memory write request (store)
- `ir_en`  out  1  load IR from memory data
- `pc_inc`  out  1  PC <= PC+1
- `pc_load`  out  1  PC <= target (jump or taken branch)
- `alu_op`  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
- `alu_src`  out  1  0 = register B, 1 = immediate
- `write_en`  out  1  register-file write
- `wb_sel`  out  1  0 = ALU result, 1 = memory data
- `instr_done`  out  1  single-cycle pulse in the final state of each instruction
- `halted`  out  1  controller in HALT
- `err`  out  1  memory timeout occurred; sticky until reset

## Operation
- Opcode map:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT: register-register operations.
  - 0101 ADDI
  - 1000 LW, 1001 SW
  - 1010 BEQ
  - 1100 J
  - 1111 HLT
  - All other opcodes are illegal and execute as a NOP.
- States: INIT, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are Moore functions of the state and `op_q`. `op_q` is the opcode registered on the DECODE cycle. Any output not listed for a state is 0.
- INIT: all outputs 0. Next state is FETCH.
- FETCH: `mem_rd`=1. Holds while `mem_ready`=0. In the cycle with `mem_ready`=1: `ir_en`=1, `pc_inc`=1, next state DECODE.
- DECODE: captures `opcode` into `op_q`. Transitions:
  - J: `pc_load`=1, `instr_done`=1, next FETCH.
  - HLT: next HALT.
  - Illegal opcode: `instr_done`=1, next FETCH.
  - Otherwise: next EXEC.
- EXEC:
  - Register-register ops: `alu_op` per the opcode (ADD→000 … SLT→100), `alu_src`=0, next WB.
  - ADDI: `alu_op`=000, `alu_src`=1, next WB.
  - LW/SW: `alu_op`=000, `alu_src`=1, next MEM.
  - BEQ: `alu_op`=001, `alu_src`=0, `pc_load`=`zero`, `instr_done`=1, next FETCH.
- MEM: `mem_rd`=1 for LW, `mem_wr`=1 for SW. Holds until `mem_ready`. On `mem_ready`: LW goes to WB; SW asserts `instr_done`=1 and goes to FETCH.
- WB: `write_en`=1, `wb_sel`=1 for LW and 0 otherwise, `instr_done`=1, next FETCH.
- HALT: `halted`=1. The state is absorbing; only `rst` leaves it.
- `write_en` is asserted only in WB, so exactly once per register-writing instruction.
- `mem_rd` and `mem_wr` are never asserted together.

## Timing
- Reset: `rst` high at a rising edge puts the controller in INIT, clears `op_q`, and clears `err`. All outputs are 0 during INIT.
- FETCH is entered on the first edge after `rst` deasserts.
- Latency with zero-wait memory (`mem_ready` held 1), FETCH to the `instr_done` cycle inclusive:
  - J: 2 cycles
  - BEQ: 3 cycles
  - Register-register ops and ADDI: 4 cycles
  - SW: 4 cycles
  - LW: 5 cycles
- Each memory wait cycle adds 1 cycle.
- `mem_ready` is ignored outside FETCH and MEM.
- `rst` asserted in any state, including mid-MEM or HALT, takes effect on that edge. Any pending access is abandoned.

## Configuration
- `MCTRL_TIMEOUT_EN` defined:
  - A 4-bit wait counter counts consecutive cycles in FETCH or MEM with `mem_ready`=0.
  - When the count reaches `TIMEOUT_CYC`, the next state is HALT and `err` is set.
  - The counter clears on state change and on reset.
- Undefined: waits are unbounded and `err` is tied to 0.

## Test plan
- Reset, then release `rst` with `mem_ready`=1 → one INIT cycle with all outputs 0; FETCH shows `mem_rd`=1, `ir_en`=1, `pc_inc`=1.
- `opcode`=0001 (SUB), zero-wait memory → EXEC shows `alu_op`=001, `alu_src`=0; WB shows `write_en`=1, `wb_sel`=0; `instr_done` pulses in cycle 4.
- LW (1000) with `mem_ready` low for 3 cycles in MEM → `mem_rd` held 4 cycles; WB shows `wb_sel`=1; total 8 cycles.
- BEQ (1010) with `zero`=1, then `zero`=0 → `pc_load`=1, then `pc_load`=0, in EXEC; 3 cycles each.
- HLT (1111) → `halted`=1 and stays for 20 cycles regardless of `opcode`; `rst` returns the controller to INIT.
- With `MCTRL_TIMEOUT_EN` defined: SW with `mem_ready` stuck at 0 → HALT with `err`=1 after 15 MEM cycles. A second run with `rst` pulsed mid-MEM → INIT next cycle, `mem_wr`=0.
